// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and word geometry.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD    = 4;
  localparam int DEFAULT_MEM_BYTES = 1024;

endpackage

// File: rtl/imem_loader_if.sv
// Word stream into the loader plus the byte-wide memory write port it drives.
interface imem_loader_if;

  logic        word_valid;
  logic [31:0] word_data;
  logic        word_last;
  logic        word_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;

  modport master (
    output word_valid, word_data, word_last,
    input  word_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  word_valid, word_data, word_last,
    output word_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_byte_lane_sel.sv
// Combinational little-endian byte select: lane 0 is word[7:0].
module imem_byte_lane_sel
  import imem_loader_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  idx,
  output logic [7:0]  lane
);

  logic [7:0] lanes [BYTES_PER_WORD];

  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
    assign lanes[gi] = word[8*gi +: 8];
  end

  assign lane = lanes[idx];

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit words into byte-wide instruction memory, little-endian, one byte per cycle.
// Define IMEM_LOADER_CHECKSUM_EN to build the per-session word checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [63:0]      base_addr,
  imem_loader_if.slave     ld,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_written,
  output logic [31:0]      checksum
);

  state_t           state_reg, state_next;
  logic [63:0]      cur_addr_reg;
  logic [31:0]      word_reg;
  logic             last_reg;
  logic [1:0]       byte_idx_reg;
  logic [CNT_W-1:0] words_written_reg;
  logic             err_reg;
  logic             armed_reg;
  logic             mem_we_reg;
  logic [63:0]      mem_addr_reg;
  logic [7:0]       mem_wdata_reg;

  logic        handshake;
  logic        range_bad;
  logic        start_ok;
  logic        word_done;
  logic [64:0] end_addr;
  logic [31:0] sel_word;
  logic [1:0]  sel_idx;
  logic [7:0]  sel_lane;

  // 65-bit sum so an address near 2^64 fails the range check instead of wrapping
  assign end_addr  = {1'b0, cur_addr_reg} + 65'd3;
  assign range_bad = end_addr > 65'(MEM_BYTES - 1);
  // armed_reg blocks a start sampled on the first edge after reset release
  assign start_ok  = start && armed_reg && (state_reg == IDLE);
  assign handshake = (state_reg == ACCEPT) && ld.word_valid;
  assign word_done = (state_reg == WRITE) && (byte_idx_reg == 2'd3);

  // Byte 0 is issued straight from the handshake; later bytes come from the latched word
  assign sel_word = (state_reg == ACCEPT) ? ld.word_data : word_reg;
  assign sel_idx  = (state_reg == ACCEPT) ? 2'd0 : byte_idx_reg + 2'd1;

  imem_byte_lane_sel u_lane_sel (
    .word (sel_word),
    .idx  (sel_idx),
    .lane (sel_lane)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (start_ok) state_next = ACCEPT;
      ACCEPT: if (handshake) state_next = range_bad ? DONE : WRITE;
      WRITE:  if (word_done) state_next = last_reg ? DONE : ACCEPT;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_reg != IDLE);
    done          = (state_reg == DONE);
    ld.word_ready = (state_reg == ACCEPT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr_reg      <= '0;
      word_reg          <= '0;
      last_reg          <= 1'b0;
      byte_idx_reg      <= '0;
      words_written_reg <= '0;
      err_reg           <= 1'b0;
      armed_reg         <= 1'b0;
      mem_we_reg        <= 1'b0;
      mem_addr_reg      <= '0;
      mem_wdata_reg     <= '0;
    end else begin
      armed_reg  <= 1'b1;
      mem_we_reg <= 1'b0;
      if (start_ok) begin
        cur_addr_reg      <= base_addr;
        words_written_reg <= '0;
        err_reg           <= 1'b0;
      end
      if (handshake) begin
        if (range_bad) begin
          err_reg <= 1'b1;
        end else begin
          word_reg      <= ld.word_data;
          last_reg      <= ld.word_last;
          byte_idx_reg  <= 2'd0;
          mem_we_reg    <= 1'b1;
          mem_addr_reg  <= cur_addr_reg + 64'(sel_idx);
          mem_wdata_reg <= sel_lane;
        end
      end
      if (state_reg == WRITE) begin
        byte_idx_reg <= byte_idx_reg + 2'd1;
        if (word_done) begin
          cur_addr_reg      <= cur_addr_reg + 64'(BYTES_PER_WORD);
          words_written_reg <= words_written_reg + 1'b1;
        end else begin
          mem_we_reg    <= 1'b1;
          mem_addr_reg  <= cur_addr_reg + 64'(sel_idx);
          mem_wdata_reg <= sel_lane;
        end
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         checksum_reg <= '0;
    else if (start_ok)  checksum_reg <= '0;
    else if (word_done) checksum_reg <= checksum_reg + word_reg;
  end

  assign checksum = checksum_reg;
`else
  assign checksum = '0;
`endif

  assign err           = err_reg;
  assign words_written = words_written_reg;
  assign ld.mem_we     = mem_we_reg;
  assign ld.mem_addr   = mem_addr_reg;
  assign ld.mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a session model predicts the byte writes, a monitor checks them.
module tb_imem_loader;

  localparam int MEM_BYTES = 1024;
  localparam int CNT_W     = 16;
  localparam int AW        = $clog2(MEM_BYTES);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [63:0]      base_addr = '0;
  logic             busy, done, err;
  logic [CNT_W-1:0] words_written;
  logic [31:0]      checksum;

  imem_loader_if bus();

  imem_loader #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .ld            (bus),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .words_written (words_written),
    .checksum      (checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  data;
  } wr_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  wr_t         exp_q[$];
  logic [31:0] sess_w[$];
  logic [7:0]  mem [MEM_BYTES];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every byte write must match the head of the expected queue
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (done) done_cnt++;
      if (bus.word_ready)
        chk("ready_only_in_accept", {61'd0, busy, bus.mem_we, done}, 64'd4);
      if (bus.mem_we) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", bus.mem_addr, e.addr);
          chk("wr_data", {56'd0, bus.mem_wdata}, {56'd0, e.data});
          $display("write addr=0x%0h data=0x%02h", bus.mem_addr, bus.mem_wdata);
        end
        if (bus.mem_addr < 64'(MEM_BYTES)) mem[bus.mem_addr[AW-1:0]] = bus.mem_wdata;
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input logic last);
    int t = 0;
    bus.word_valid = 1'b1;
    bus.word_data  = w;
    bus.word_last  = last;
    while (!bus.word_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.word_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL handshake_timeout: got word_ready=0 after %0d cycles, expected 1", t);
    end
    @(negedge clk);
    bus.word_valid = 1'b0;
    bus.word_last  = 1'b0;
    bus.word_data  = $urandom;
  endtask

  // One load session: model the expected image from the words in sess_w, then drive it
  task automatic run_session(input logic [63:0] base, input int gap_lo, input int gap_hi,
                             input bit inject_start);
    logic [63:0] a = base;
    logic [31:0] sum = '0;
    logic [31:0] w;
    logic [31:0] exp_ck;
    int          cnt = 0;
    int          sent = 0;
    int          t = 0;
    bit          e_err = 1'b0;
    wr_t         wr;
    int          n = sess_w.size();

    for (int i = 0; i < n; i++) begin
      sent++;
      if (a > 64'(MEM_BYTES - 4)) begin
        e_err = 1'b1;
        break;
      end
      w = sess_w[i];
      for (int b = 0; b < 4; b++) begin
        wr.addr = a + 64'(b);
        wr.data = w[8*b +: 8];
        exp_q.push_back(wr);
      end
      a   = a + 64'd4;
      cnt = cnt + 1;
      sum = sum + w;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_ck = sum;
`else
    exp_ck = 32'd0;
`endif

    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    done_cnt  = 0;
    @(negedge clk);
    start     = 1'b0;
    base_addr = {$urandom, $urandom};
    chk("busy_after_start", {63'd0, busy}, 64'd1);

    for (int i = 0; i < sent; i++) begin
      send_word(sess_w[i], (i == n - 1));
      if (inject_start && i == 0) begin
        start     = 1'b1;
        base_addr = base + 64'h100;
        @(negedge clk);
        start     = 1'b0;
      end
      if (i < sent - 1) repeat ($urandom_range(gap_hi, gap_lo)) @(negedge clk);
    end

    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
    chk("words_written", {48'd0, words_written}, 64'(cnt));
    chk("err", {63'd0, err}, {63'd0, e_err});
    chk("checksum", {32'd0, checksum}, {32'd0, exp_ck});
    @(negedge clk);
    chk("busy_after_done", {63'd0, busy}, 64'd0);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("session base=0x%0h words=%0d written=%0d err=%0b checksum=0x%08h",
             base, n, words_written, err, checksum);
  endtask

  initial begin
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    bus.word_last  = 1'b0;

    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_words", {48'd0, words_written}, 64'd0);
    chk("rst_checksum", {32'd0, checksum}, 64'd0);
    chk("rst_ready", {63'd0, bus.word_ready}, 64'd0);
    chk("rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'd0);
    chk("rst_mem_wdata", {56'd0, bus.mem_wdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single word, then read back through the fetch view
    sess_w = '{32'h40302513};
    run_session(64'd0, 0, 0, 1'b0);
    chk("fetch_pc0", {32'd0, mem[3], mem[2], mem[1], mem[0]}, 64'h40302513);

    // Three words with two idle cycles between them
    sess_w = '{32'h11223344, 32'h55667788, 32'h99aabbcc};
    run_session(64'h10, 2, 2, 1'b0);

    // Range errors: past the top of memory, and near the 64-bit wrap
    sess_w = '{32'hdeadbeef};
    run_session(64'd1021, 0, 0, 1'b0);
    sess_w = '{32'hcafef00d, 32'h12345678};
    run_session(64'hffff_ffff_ffff_fffe, 0, 0, 1'b0);

    // start pulsed mid-write with a different base is ignored
    sess_w = '{32'ha1a2a3a4, 32'hb1b2b3b4};
    run_session(64'h80, 0, 1, 1'b1);

    // Checksum wraps modulo 2^32
    sess_w = '{32'hffffffff, 32'h00000002};
    run_session(64'h100, 0, 0, 1'b0);

    // Reset asserted while byte 2 is on the write port
    @(negedge clk);
    start     = 1'b1;
    base_addr = 64'h200;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      wr_t wr;
      wr.addr = 64'h200 + 64'(b);
      wr.data = 8'(32'h0badf00d >> (8 * b));
      exp_q.push_back(wr);
    end
    send_word(32'h0badf00d, 1'b1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_words", {48'd0, words_written}, 64'd0);
    chk("bytes_left_at_rst", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    // start coinciding with reset release must be ignored
    @(negedge clk);
    rst_n     = 1'b1;
    start     = 1'b1;
    base_addr = 64'h300;
    @(negedge clk);
    start = 1'b0;
    chk("start_at_rst_release", {63'd0, busy}, 64'd0);
    sess_w = '{32'h01020304, 32'h05060708};
    run_session(64'h300, 0, 0, 1'b0);

    // Random sessions: unaligned bases, some crossing the end of memory
    for (int s = 0; s < 14; s++) begin
      int n = $urandom_range(5, 1);
      sess_w.delete();
      for (int i = 0; i < n; i++) sess_w.push_back($urandom);
      run_session(64'($urandom_range(1040, 0)), 0, 3, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no completion, expected $finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
